// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential unsigned multiplier:
// FSM state enum, width helpers and a mod-3 reduction for any width up to 64 bits.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RES_MAX_W = 64;

  // Iteration counter width: it must hold the value WIDTH itself.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int calc_pw(input int width);
    return 2 * width;
  endfunction

  // Since 4 == 1 (mod 3), summing base-4 digits keeps the residue.
  function automatic logic [1:0] mod3(input logic [RES_MAX_W-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < RES_MAX_W / 2; i++) begin
      r = r + {1'b0, v[2*i +: 2]};
      if (r >= 3'd3) r = r - 3'd3;
    end
    return r[1:0];
  endfunction

endpackage

// File: rtl/mult_seq_unsigned_if.sv
// Operand/product handshake bundle for mult_seq_unsigned.
// The master drives operands and out_ready; the slave (multiplier) drives the rest.
interface mult_seq_unsigned_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  logic               err;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy, err
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy, err
  );
endinterface

// File: rtl/mult_seq_mod3.sv
// Combinational mod-3 residue of a W-bit unsigned value (W up to 64).
module mult_seq_mod3
  import mult_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_x,
  output logic [1:0]   o_res
);
  assign o_res = mod3(RES_MAX_W'(i_x));
endmodule

// File: rtl/mult_seq_unsigned.sv
// Sequential radix-2 shift-add unsigned WIDTH x WIDTH multiplier, valid/ready on both sides.
// Define MULT_SEQ_RESIDUE_CHECK_EN to add the mod-3 residue checker that drives err.
module mult_seq_unsigned
  import mult_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_seq_unsigned_if.slave bus
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam int PW    = calc_pw(WIDTH);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mult_seq_unsigned: WIDTH must be within 2..32");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_acc_shift;
  logic             w_zero;
  logic             w_last;

  // One shift-add step; the adder carry lands in the top product bit after the shift.
  always_comb begin
    w_sum       = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_last      = (w_cnt_nxt == CNT_W'(WIDTH));
    w_zero      = (bus.a == '0) || (bus.b == '0);
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = (ZERO_SKIP && w_zero) ? DONE : BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand <= bus.a;
            r_acc   <= {{WIDTH{1'b0}}, bus.b};
            r_cnt   <= '0;
            if (ZERO_SKIP && w_zero) r_p <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_acc_shift;
          r_cnt <= w_cnt_nxt;
          if (w_last) r_p <= w_acc_shift;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == BUSY);
  assign bus.p         = r_p;

`ifdef MULT_SEQ_RESIDUE_CHECK_EN
  logic [1:0] w_res_a;
  logic [1:0] w_res_b;
  logic [1:0] w_res_p;
  logic [1:0] w_res_ab;
  logic [3:0] w_res_prod;
  logic [1:0] r_ra;
  logic [1:0] r_rb;
  logic       r_err;

  mult_seq_mod3 #(.W(WIDTH)) u_mod3_a (.i_x(bus.a),       .o_res(w_res_a));
  mult_seq_mod3 #(.W(WIDTH)) u_mod3_b (.i_x(bus.b),       .o_res(w_res_b));
  mult_seq_mod3 #(.W(PW))    u_mod3_p (.i_x(w_acc_shift), .o_res(w_res_p));

  assign w_res_prod = {2'b00, r_ra} * {2'b00, r_rb};
  assign w_res_ab   = mod3(RES_MAX_W'(w_res_prod));

  // Advisory flag: compared against the value being loaded into p, held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra  <= '0;
      r_rb  <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_ra  <= w_res_a;
            r_rb  <= w_res_b;
            r_err <= 1'b0;
          end
        end
        BUSY: begin
          if (w_last) r_err <= (w_res_ab != w_res_p);
        end
        DONE: begin
          if (bus.out_ready) r_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_unsigned.sv
// Directed bench for mult_seq_unsigned: WIDTH=4 with and without zero-skip, plus WIDTH=16.
// Define MULT_SEQ_RESIDUE_CHECK_EN to also run the residue fault-injection scenario.
module tb_mult_seq_unsigned;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mult_seq_unsigned_if #(.WIDTH(4))  m4  ();
  mult_seq_unsigned_if #(.WIDTH(4))  mn  ();
  mult_seq_unsigned_if #(.WIDTH(16)) m16 ();

  mult_seq_unsigned #(.WIDTH(4), .ZERO_SKIP(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m4)
  );

  mult_seq_unsigned #(.WIDTH(4), .ZERO_SKIP(1'b0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mn)
  );

  mult_seq_unsigned #(.WIDTH(16), .ZERO_SKIP(1'b1)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // sel: 0 = WIDTH 4 zero-skip, 1 = WIDTH 4 no zero-skip, 2 = WIDTH 16 zero-skip
  function automatic logic rd_ready(input int sel);
    case (sel)
      0:       rd_ready = m4.in_ready;
      1:       rd_ready = mn.in_ready;
      default: rd_ready = m16.in_ready;
    endcase
  endfunction

  function automatic logic rd_valid(input int sel);
    case (sel)
      0:       rd_valid = m4.out_valid;
      1:       rd_valid = mn.out_valid;
      default: rd_valid = m16.out_valid;
    endcase
  endfunction

  function automatic logic rd_busy(input int sel);
    case (sel)
      0:       rd_busy = m4.busy;
      1:       rd_busy = mn.busy;
      default: rd_busy = m16.busy;
    endcase
  endfunction

  function automatic logic rd_err(input int sel);
    case (sel)
      0:       rd_err = m4.err;
      1:       rd_err = mn.err;
      default: rd_err = m16.err;
    endcase
  endfunction

  function automatic logic [31:0] rd_p(input int sel);
    case (sel)
      0:       rd_p = 32'(m4.p);
      1:       rd_p = 32'(mn.p);
      default: rd_p = m16.p;
    endcase
  endfunction

  task automatic drive(input int sel, input logic iv, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy);
    case (sel)
      0: begin
        m4.in_valid = iv; m4.a = a[3:0]; m4.b = b[3:0]; m4.out_ready = ordy;
      end
      1: begin
        mn.in_valid = iv; mn.a = a[3:0]; mn.b = b[3:0]; mn.out_ready = ordy;
      end
      default: begin
        m16.in_valid = iv; m16.a = a; m16.b = b; m16.out_ready = ordy;
      end
    endcase
  endtask

  // One complete transaction: accept, wait for the product, stall, then hand it off.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input int exp_lat, input logic [31:0] exp_p,
                        input string tag);
    int          n;
    int          lat;
    int          nbusy;
    logic [31:0] got_p;
    logic        got_err;
    logic        unstable;
    @(negedge clk);
    drive(sel, 1'b1, a, b, 1'b0);
    n = 0;
    while (rd_ready(sel) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s accept_timeout: in_ready never rose (a=%0d b=%0d)", tag, a, b);
    end
    @(negedge clk);
    drive(sel, 1'b0, a, b, 1'b0);
    lat   = 0;
    nbusy = 0;
    while (rd_valid(sel) !== 1'b1 && lat < 100) begin
      if (rd_busy(sel) === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d (a=%0d b=%0d)", tag, lat, exp_lat, a, b);
    end
    checks++;
    if (nbusy !== exp_lat) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d (a=%0d b=%0d)", tag, nbusy, exp_lat, a, b);
    end
    got_p   = rd_p(sel);
    got_err = rd_err(sel);
    checks++;
    if (got_p !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %0d, expected %0d (a=%0d b=%0d)", tag, got_p, exp_p, a, b);
    end
    checks++;
    if (got_err !== 1'b0) begin
      errors++;
      $display("FAIL %s err: got %b, expected 0 (a=%0d b=%0d)", tag, got_err, a, b);
    end
    if (stall > 0) begin
      unstable = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (rd_p(sel) !== got_p || rd_valid(sel) !== 1'b1) unstable = 1'b1;
      end
      checks++;
      if (unstable !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_hold: p/out_valid changed during %0d stall cycles", tag, stall);
      end
    end
    drive(sel, 1'b0, a, b, 1'b1);
    @(negedge clk);
    drive(sel, 1'b0, a, b, 1'b0);
    checks++;
    if (rd_valid(sel) !== 1'b0 || rd_ready(sel) !== 1'b1 || rd_p(sel) !== exp_p) begin
      errors++;
      $display("FAIL %s handoff: out_valid=%b in_ready=%b p=%0d, expected 0/1/%0d",
               tag, rd_valid(sel), rd_ready(sel), rd_p(sel), exp_p);
    end
  endtask

  task automatic test_reset;
    m4.in_valid = 1'b0;  m4.a = '0;  m4.b = '0;  m4.out_ready = 1'b0;
    mn.in_valid = 1'b0;  mn.a = '0;  mn.b = '0;  mn.out_ready = 1'b0;
    m16.in_valid = 1'b0; m16.a = '0; m16.b = '0; m16.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (m4.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, expected 1", m4.in_ready);
    end
    checks++;
    if (m4.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, expected 0", m4.out_valid);
    end
    checks++;
    if (m4.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, expected 0", m4.busy);
    end
    checks++;
    if (m4.p !== 8'h00) begin
      errors++; $display("FAIL reset_p: got %h, expected 00", m4.p);
    end
    checks++;
    if (m4.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b, expected 0", m4.err);
    end
    checks++;
    if (m16.p !== 32'h0 || m16.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_w16: p=%h in_ready=%b, expected 0/1", m16.p, m16.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m4.in_ready !== 1'b1 || mn.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b/%b, expected 1/1", m4.in_ready, mn.in_ready);
    end
  endtask

  task automatic test_max;
    run_op(0, 16'd15, 16'd15, 0, 4, 32'd225, "max_w4");
    run_op(1, 16'd15, 16'd15, 2, 4, 32'd225, "max_w4_noskip");
    run_op(2, 16'hFFFF, 16'hFFFF, 1, 16, 32'hFFFE_0001, "max_w16");
    run_op(2, 16'h8000, 16'h0002, 0, 16, 32'h0001_0000, "carry_w16");
  endtask

  task automatic test_zero_skip;
    run_op(0, 16'd0, 16'd9, 0, 0, 32'd0, "zskip_a0");
    run_op(0, 16'd7, 16'd0, 1, 0, 32'd0, "zskip_b0");
    run_op(1, 16'd0, 16'd9, 0, 4, 32'd0, "noskip_a0");
    run_op(2, 16'd0, 16'hFFFF, 0, 0, 32'd0, "zskip_w16");
  endtask

  task automatic test_backpressure;
    int   n;
    logic bad;
    @(negedge clk);
    drive(0, 1'b1, 16'd6, 16'd7, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'd1, 16'd1, 1'b0);
    n = 0;
    while (m4.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL bp_latency: got %0d cycles, expected 4", n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m4.p !== 8'd42 || m4.out_valid !== 1'b1 || m4.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: p=%0d out_valid=%b in_ready=%b, expected 42/1/0",
                 i, m4.p, m4.out_valid, m4.in_ready);
      end
      @(negedge clk);
    end
    drive(0, 1'b0, 16'd1, 16'd1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 16'd1, 16'd1, 1'b0);
    checks++;
    if (m4.out_valid !== 1'b0 || m4.in_ready !== 1'b1 || m4.p !== 8'd42) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b p=%0d, expected 0/1/42",
               m4.out_valid, m4.in_ready, m4.p);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m4.busy !== 1'b0 || m4.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL bp_no_accept: operands offered while busy were taken");
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(0, 1'b1, 16'd13, 16'd11, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'd13, 16'd11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m4.out_valid !== 1'b0 || m4.p !== 8'd0 || m4.busy !== 1'b0 || m4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b p=%0d busy=%b in_ready=%b, expected 0/0/0/1",
               m4.out_valid, m4.p, m4.busy, m4.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'd3, 16'd5, 0, 4, 32'd15, "after_reset");
  endtask

  // Holds in_valid and out_ready high; products must appear at a fixed initiation interval.
  task automatic b2b_seq(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input int first, input int period,
                         input int nsamp, input int exp_hits, input string tag);
    int hits;
    int bad_pos;
    @(negedge clk);
    drive(sel, 1'b1, a, b, 1'b1);
    hits    = 0;
    bad_pos = 0;
    for (int i = 0; i < nsamp; i++) begin
      if (rd_valid(sel) === 1'b1) begin
        hits++;
        if (i < first || ((i - first) % period) != 0) bad_pos++;
        checks++;
        if (rd_p(sel) !== exp_p) begin
          errors++; $display("FAIL %s product[%0d]: got %0d, expected %0d", tag, i, rd_p(sel), exp_p);
        end
      end
      @(negedge clk);
    end
    drive(sel, 1'b0, a, b, 1'b0);
    checks++;
    if (hits !== exp_hits) begin
      errors++; $display("FAIL %s count: got %0d products, expected %0d", tag, hits, exp_hits);
    end
    checks++;
    if (bad_pos !== 0) begin
      errors++; $display("FAIL %s interval: %0d products off the %0d-cycle grid", tag, bad_pos, period);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    b2b_seq(0, 16'd3, 16'd5, 32'd15, 5, 6, 18, 3, "b2b_w4");
    b2b_seq(0, 16'd0, 16'd5, 32'd0, 1, 2, 8, 4, "b2b_zskip");
  endtask

  task automatic test_exhaustive;
    int exp_lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_lat = (a == 0 || b == 0) ? 0 : 4;
        run_op(0, 16'(a), 16'(b), $urandom_range(0, 3), exp_lat, 32'(a * b), "exh_w4");
        run_op(1, 16'(a), 16'(b), $urandom_range(0, 2), 4, 32'(a * b), "exh_w4_noskip");
      end
    end
  endtask

  task automatic test_random16;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
    for (int i = 0; i < 150; i++) begin
      a     = 16'($urandom);
      b     = 16'($urandom);
      exp_p = 32'(a) * 32'(b);
      run_op(2, a, b, $urandom_range(0, 3), (a == 0 || b == 0) ? 0 : 16, exp_p, "rand_w16");
    end
  endtask

`ifdef MULT_SEQ_RESIDUE_CHECK_EN
  // 5*7: after the first iteration acc is 0x2B; flipping bit 7 adds 128>>3 = 16, so p becomes 51.
  task automatic test_residue_fault;
    logic [7:0] flipped;
    int         n;
    @(negedge clk);
    drive(0, 1'b1, 16'd5, 16'd7, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'd5, 16'd7, 1'b0);
    @(negedge clk);
    flipped = dut.r_acc ^ 8'h80;
    force dut.r_acc = flipped;
    #1;
    release dut.r_acc;
    n = 0;
    while (m4.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m4.p !== 8'd51) begin
      errors++; $display("FAIL residue_fault_p: got %0d, expected 51", m4.p);
    end
    checks++;
    if (m4.err !== 1'b1) begin
      errors++; $display("FAIL residue_fault_err: got %b, expected 1", m4.err);
    end
    drive(0, 1'b0, 16'd5, 16'd7, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 16'd5, 16'd7, 1'b0);
    checks++;
    if (m4.err !== 1'b0) begin
      errors++; $display("FAIL residue_err_clear: got %b, expected 0", m4.err);
    end
    run_op(0, 16'd5, 16'd7, 0, 4, 32'd35, "residue_clean");
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_max();
    test_zero_skip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive();
    test_random16();
`ifdef MULT_SEQ_RESIDUE_CHECK_EN
    test_residue_fault();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
